ahb_sram_slv: RTL and testbench
===============================

# ahb_sram_slv

AHB slave memory that sits directly downstream of the 2-master/2-slave AHB interconnect and is driven by one S*_HSEL / S*_HREADY / S*_HRESP / S*_HRDATA slot plus the shared S_H* address and control bus. It decodes each address phase, inserts a programmable number of wait states, performs byte, halfword and word accesses on an internal little-endian array, and returns the two-cycle AHB ERROR response for illegal transfers.

## Interface
- P_SLV_ID, 0: slave index; for simulation messages only.
- P_SIZE_IN_BYTES, 1024: array size; power of two, ≥ 4.
- P_DELAY, 0: wait states per data phase, 0–15.
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESET  in  1  reset, synchronous and active-high.
- HSEL  in  1  slave select from the interconnect decoder.
- HADDR  in  32  address; offset = HADDR[log2(P_SIZE_IN_BYTES)-1:0].
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HBURST  in  3  accepted and ignored; every beat is handled independently.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYin  in  1  bus-wide HREADY.
- HRDATA  out  32  read data.
- HRESP  out  2  OKAY=0, ERROR=1.
- HREADYout  out  1  this slave's ready.

## Operation
- A transfer is accepted when HSEL & HREADYin & HTRANS[1] are high at a rising HCLK edge. On acceptance the block registers the address offset, HWRITE and HSIZE and computes the lane mask.
- IDLE or BUSY with HSEL high, and any cycle with HSEL low: no access; the next data phase is zero-wait OKAY.
- FSM states:
  - ST_IDLE: no data phase pending.
  - ST_WAIT: counter running.
  - ST_DATA: completing beat, HREADYout=1.
  - ST_ERR1, ST_ERR2: error response cycles.
- FSM transitions:
  - Accept legal transfer: to ST_WAIT if P_DELAY>0 (counter loads P_DELAY-1), otherwise to ST_DATA.
  - ST_WAIT: goes to ST_DATA when the counter reaches 0.
  - ST_DATA / ST_ERR2: accept the next transfer back-to-back, else go to ST_IDLE.
  - Illegal accept: to ST_ERR1, then ST_ERR2.
- Byte lanes, little-endian:
  - Byte: lane = addr[1:0].
  - Halfword: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- Write: at the ST_DATA edge, only the masked HWDATA lanes are written to word offset[..:2].
- Read: in ST_DATA, HRDATA = full 32-bit array word at the registered offset. HRDATA=0 in every other state.
- Write then read of the same word back-to-back: the read returns the newly written data, because the write commits on the same edge that accepts the read.
- Memory contents are not cleared by reset.

## Timing
- Reset values (HRESET sampled high at an edge), effective after that edge:
  - state = ST_IDLE, counter = 0.
  - HREADYout = 1, HRESP = OKAY, HRDATA = 0.
  - Any in-flight beat is discarded and no write occurs.
- Data-phase length is P_DELAY+1 cycles. HREADYout is low for exactly P_DELAY cycles, then high for 1.
- HRESP = OKAY throughout a legal beat.
- Error response:
  - ST_ERR1: HREADYout=0, HRESP=ERROR.
  - ST_ERR2: HREADYout=1, HRESP=ERROR.
  - No array write and HRDATA=0. P_DELAY is not applied.
- Address phases are not sampled while HREADYin is low. The registered beat is held unchanged.

## Configuration
- AHB_SLV_ERR_EN defined — a transfer is illegal if any of these holds:
  - HSIZE > 2.
  - Halfword with addr[0]=1.
  - Word with addr[1:0] ≠ 0.
  - Illegal transfers take the two-cycle ERROR path.
- AHB_SLV_ERR_EN undefined:
  - No ERROR is ever produced; HRESP is tied to OKAY and ST_ERR1/ST_ERR2 are never entered.
  - Misaligned transfers are forced aligned (halfword clears addr[0], word clears addr[1:0]).
  - HSIZE > 2 is treated as a word.

## Structure
- Package ahb_sram_pkg holds:
  - HTRANS, HRESP and HSIZE code constants.
  - The FSM state encoding.
  - The width of the wait-state counter.
- Sub-module ahb_lane_mask: combinational (HSIZE, addr[1:0]) → 4-bit lane mask plus a misaligned flag. It is instantiated once.

## Test plan
- Reset: HRESET high 2 cycles, mid-way through a P_DELAY=3 write → HREADYout=1, HRESP=OKAY, HRDATA=0; the target word is unchanged.
- Word write then read, P_DELAY=0:
  - Stimulus: write 0xDEADBEEF @0x10, immediately followed by a read @0x10.
  - Response: both data phases 1 cycle; HRDATA=0xDEADBEEF.
- Byte lanes, after word 0x00000000 @0x20:
  - Stimulus: byte writes 0xAA @0x21 and 0x55 @0x23.
  - Response: a word read returns 0x5500AA00.
- Wait states, P_DELAY=2: read @0x0 → HREADYout sequence 0,0,1; HRDATA valid only in the third cycle.
- Error, AHB_SLV_ERR_EN defined:
  - Stimulus: word write @0x2.
  - Response: ERROR with HREADYout 0 then 1; a read @0x0 returns the prior contents.
- Error, macro undefined: the same stimulus writes word 0x0 with OKAY.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// Shared constants, FSM encoding and helpers for the AHB SRAM slave.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Wide enough to hold the largest preload (15 wait states minus one).
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are no-ops.
  function automatic logic transActive(input logic [1:0] trans);
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: transActive = 1'b1;
      HTRANS_IDLE,   HTRANS_BUSY: transActive = 1'b0;
      default:                    transActive = 1'b0;
    endcase
  endfunction

  // Counter preload for a data phase with the given number of wait states.
  function automatic logic [CNT_W-1:0] delayLoad(input int delay);
    delayLoad = (delay > 0) ? CNT_W'(delay - 1) : '0;
  endfunction

endpackage

// File: rtl/ahb_lane_mask.sv
// Little-endian byte-lane decode for an AHB transfer, plus a flag
// reporting whether the address is misaligned for the requested size.
// The mask is always the aligned one, so callers that ignore the flag
// get the forced-alignment behaviour for free.
module ahb_lane_mask
  import ahb_sram_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_mask,
  output logic       o_misaligned
);

  // Pick the active lanes; sizes above a word are handled as a word.
  always_comb begin
    o_mask       = 4'b1111;
    o_misaligned = 1'b0;
    case (i_size)
      HSIZE_BYTE: begin
        o_mask       = 4'b0001 << i_addr;
        o_misaligned = 1'b0;
      end
      HSIZE_HALF: begin
        o_mask       = i_addr[1] ? 4'b1100 : 4'b0011;
        o_misaligned = i_addr[0];
      end
      HSIZE_WORD: begin
        o_mask       = 4'b1111;
        o_misaligned = |i_addr;
      end
      default: begin
        o_mask       = 4'b1111;
        o_misaligned = |i_addr;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slv.sv
// AHB slave backed by a little-endian word array with a programmable
// number of wait states per data phase.
// Optional feature macro: AHB_SLV_ERR_EN -- when defined, oversized or
// misaligned transfers get the two-cycle ERROR response; when undefined,
// they are silently aligned and HRESP stays OKAY.
module ahb_sram_slv
  import ahb_sram_pkg::*;
#(
  parameter int P_SLV_ID        = 0,
  parameter int P_SIZE_IN_BYTES = 1024,
  parameter int P_DELAY         = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADYin,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADYout
);

  localparam int AW    = $clog2(P_SIZE_IN_BYTES);
  localparam int WORDS = P_SIZE_IN_BYTES / 4;
  localparam int WIW   = (AW > 2) ? AW - 2 : 1;

  logic [31:0]      r_mem [WORDS];
  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [WIW-1:0]   r_wordIdx;
  logic [3:0]       r_mask;
  logic             r_write;

  logic             w_accept;
  logic             w_canAccept;
  logic             w_illegal;
  logic             w_misaligned;
  logic [3:0]       w_mask;
  logic [WIW-1:0]   w_wordIdx;
  logic             w_unused;

  assign w_accept    = HSEL & HREADYin & transActive(HTRANS);
  assign w_canAccept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_wordIdx   = HADDR[WIW+1:2] & WIW'(WORDS - 1);

  ahb_lane_mask u_laneMask (
    .i_size       (HSIZE),
    .i_addr       (HADDR[1:0]),
    .o_mask       (w_mask),
    .o_misaligned (w_misaligned)
  );

`ifdef AHB_SLV_ERR_EN
  assign w_illegal = (HSIZE > HSIZE_WORD) | w_misaligned;
  assign w_unused  = ^{HBURST, HADDR[31:AW], P_SLV_ID[0]};
`else
  assign w_illegal = 1'b0;
  assign w_unused  = ^{HBURST, HADDR[31:AW], P_SLV_ID[0], w_misaligned};
`endif

  // State register; reset drops any in-flight beat.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode: new beats are only taken when no beat is stalling.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_nextState = ST_ERR1;
          end else if (P_DELAY > 0) begin
            w_nextState = ST_WAIT;
          end else begin
            w_nextState = ST_DATA;
          end
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_nextState = ST_DATA;
        end
      end
      ST_ERR1: begin
        w_nextState = ST_ERR2;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Wait-state counter: preloaded on a legal accept, counts down while waiting.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_cnt <= '0;
    end else if (w_canAccept && w_accept && !w_illegal) begin
      r_cnt <= delayLoad(P_DELAY);
    end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Capture the address phase; held untouched while the bus is stalled.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wordIdx <= '0;
      r_mask    <= '0;
      r_write   <= 1'b0;
    end else if (w_canAccept && w_accept) begin
      r_wordIdx <= w_wordIdx;
      r_mask    <= w_mask;
      r_write   <= HWRITE & ~w_illegal;
    end
  end

  // Array write on the completing edge; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (r_state == ST_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_mask[b]) begin
          r_mem[r_wordIdx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Bus outputs derived from the current state only.
  always_comb begin
    HREADYout = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (r_state)
      ST_WAIT: begin
        HREADYout = 1'b0;
      end
      ST_DATA: begin
        if (!r_write) begin
          HRDATA = r_mem[r_wordIdx];
        end
      end
`ifdef AHB_SLV_ERR_EN
      ST_ERR1: begin
        HREADYout = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: begin
        HRESP = HRESP_ERROR;
      end
`endif
      default: begin
        HREADYout = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_slv.sv
// Directed bench for ahb_sram_slv: three instances (0, 2 and 3 wait
// states) share one AHB bus; the bench selects one at a time and feeds
// its HREADYout back as the bus-wide HREADY.
module tb_ahb_sram_slv;
  import ahb_sram_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hreadyIn;

  logic [31:0] rdata0, rdata2, rdata3;
  logic [1:0]  resp0, resp2, resp3;
  logic        rdy0, rdy2, rdy3;

  logic [31:0] rdataObs;
  logic [1:0]  respObs;
  logic        rdyObs;

  int activeDut = 0;
  int checks    = 0;
  int errors    = 0;

  always #5 HCLK = ~HCLK;

  assign rdyObs   = (activeDut == 0) ? rdy0   : (activeDut == 1) ? rdy2   : rdy3;
  assign respObs  = (activeDut == 0) ? resp0  : (activeDut == 1) ? resp2  : resp3;
  assign rdataObs = (activeDut == 0) ? rdata0 : (activeDut == 1) ? rdata2 : rdata3;
  assign hreadyIn = rdyObs;

  ahb_sram_slv #(.P_SLV_ID(0), .P_SIZE_IN_BYTES(1024), .P_DELAY(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADYin(hreadyIn), .HRDATA(rdata0), .HRESP(resp0), .HREADYout(rdy0)
  );

  ahb_sram_slv #(.P_SLV_ID(1), .P_SIZE_IN_BYTES(1024), .P_DELAY(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADYin(hreadyIn), .HRDATA(rdata2), .HRESP(resp2), .HREADYout(rdy2)
  );

  ahb_sram_slv #(.P_SLV_ID(2), .P_SIZE_IN_BYTES(1024), .P_DELAY(3)) dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADYin(hreadyIn), .HRDATA(rdata3), .HRESP(resp3), .HREADYout(rdy3)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Drive one address phase towards the currently active instance.
  task automatic applyStimulus(input logic sel, input logic [31:0] addr,
                               input logic [1:0] trans, input logic wr,
                               input logic [2:0] size);
    hsel            = '0;
    hsel[activeDut] = sel;
    haddr           = addr;
    htrans          = trans;
    hwrite          = wr;
    hsize           = size;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Step edges until the active slave is ready, with a hard cycle limit.
  task automatic waitReady(input string tag, input int maxCycles);
    int n;
    n = 0;
    while ((rdyObs !== 1'b1) && (n < maxCycles)) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'b0, rdyObs}, 32'd1);
  endtask

  initial begin
    HRESET = 1'b1;
    hwdata = '0;
    hburst = '0;
    idleBus();
    tick();
    tick();
    HRESET = 1'b0;

    checkOutput("rst_ready", {31'b0, rdyObs}, 32'd1);
    checkOutput("rst_resp",  {30'b0, respObs}, 32'd0);
    checkOutput("rst_rdata", rdataObs, 32'd0);

    // Word write then back-to-back read, no wait states.
    applyStimulus(1'b1, 32'h10, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    hwdata = 32'hDEADBEEF;
    applyStimulus(1'b1, 32'h10, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    checkOutput("wr_ready", {31'b0, rdyObs}, 32'd1);
    checkOutput("wr_resp",  {30'b0, respObs}, 32'd0);
    tick();
    idleBus();
    checkOutput("rd_ready", {31'b0, rdyObs}, 32'd1);
    checkOutput("rd_data",  rdataObs, 32'hDEADBEEF);
    tick();
    checkOutput("idle_rdata", rdataObs, 32'd0);

    // IDLE with HSEL high must not start a read.
    applyStimulus(1'b1, 32'h10, HTRANS_IDLE, 1'b0, HSIZE_WORD);
    tick();
    idleBus();
    checkOutput("idlesel_ready", {31'b0, rdyObs}, 32'd1);
    checkOutput("idlesel_rdata", rdataObs, 32'd0);
    tick();

    // Byte lanes on a cleared word; unused lanes carry junk.
    applyStimulus(1'b1, 32'h20, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    hwdata = 32'h0;
    applyStimulus(1'b1, 32'h21, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE);
    tick();
    hwdata = 32'h1111AA11;
    applyStimulus(1'b1, 32'h23, HTRANS_SEQ, 1'b1, HSIZE_BYTE);
    tick();
    hwdata = 32'h55222222;
    applyStimulus(1'b1, 32'h20, HTRANS_NONSEQ, 0, HSIZE_WORD);
    tick();
    idleBus();
    checkOutput("byte_lanes", rdataObs, 32'h5500AA00);
    tick();

    // Upper halfword overwrite.
    applyStimulus(1'b1, 32'h22, HTRANS_NONSEQ, 1'b1, HSIZE_HALF);
    tick();
    hwdata = 32'h12349999;
    applyStimulus(1'b1, 32'h20, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    idleBus();
    checkOutput("half_lanes", rdataObs, 32'h1234AA00);
    tick();

    // Seed word 0 for the error-path readback.
    applyStimulus(1'b1, 32'h0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    hwdata = 32'h01020304;
    idleBus();
    tick();

    // Misaligned word write at 0x2.
    applyStimulus(1'b1, 32'h2, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    hwdata = 32'h0BADF00D;
    applyStimulus(1'b1, 32'h0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
`ifdef AHB_SLV_ERR_EN
    checkOutput("err1_ready", {31'b0, rdyObs}, 32'd0);
    checkOutput("err1_resp",  {30'b0, respObs}, 32'd1);
    tick();
    checkOutput("err2_ready", {31'b0, rdyObs}, 32'd1);
    checkOutput("err2_resp",  {30'b0, respObs}, 32'd1);
    tick();
    idleBus();
    checkOutput("err_readback", rdataObs, 32'h01020304);
    checkOutput("err_rd_resp",  {30'b0, respObs}, 32'd0);
    tick();
`else
    checkOutput("noerr_ready", {31'b0, rdyObs}, 32'd1);
    checkOutput("noerr_resp",  {30'b0, respObs}, 32'd0);
    tick();
    idleBus();
    checkOutput("noerr_readback", rdataObs, 32'h0BADF00D);
    checkOutput("noerr_rd_resp",  {30'b0, respObs}, 32'd0);
    tick();
`endif

    // Two wait states: write then read of word 0.
    activeDut = 1;
    applyStimulus(1'b1, 32'h0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    hwdata = 32'hCAFEF00D;
    applyStimulus(1'b1, 32'h0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    checkOutput("w2_wr_wait0", {31'b0, rdyObs}, 32'd0);
    tick();
    checkOutput("w2_wr_wait1", {31'b0, rdyObs}, 32'd0);
    tick();
    checkOutput("w2_wr_done",  {31'b0, rdyObs}, 32'd1);
    tick();
    idleBus();
    checkOutput("w2_rd_wait0", {31'b0, rdyObs}, 32'd0);
    checkOutput("w2_rd_data0", rdataObs, 32'd0);
    tick();
    checkOutput("w2_rd_wait1", {31'b0, rdyObs}, 32'd0);
    checkOutput("w2_rd_data1", rdataObs, 32'd0);
    tick();
    checkOutput("w2_rd_done",  {31'b0, rdyObs}, 32'd1);
    checkOutput("w2_rd_data",  rdataObs, 32'hCAFEF00D);
    checkOutput("w2_rd_resp",  {30'b0, respObs}, 32'd0);
    tick();

    // Reset in the middle of a three-wait-state write.
    activeDut = 2;
    applyStimulus(1'b1, 32'h40, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    hwdata = 32'h12345678;
    idleBus();
    waitReady("w3_seed_ready", 8);
    tick();
    applyStimulus(1'b1, 32'h40, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    hwdata = 32'hFFFFFFFF;
    idleBus();
    tick();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    checkOutput("rstmid_ready", {31'b0, rdyObs}, 32'd1);
    checkOutput("rstmid_resp",  {30'b0, respObs}, 32'd0);
    checkOutput("rstmid_rdata", rdataObs, 32'd0);
    applyStimulus(1'b1, 32'h40, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    idleBus();
    checkOutput("rstmid_wait", {31'b0, rdyObs}, 32'd0);
    waitReady("rstmid_rd_ready", 8);
    checkOutput("rstmid_readback", rdataObs, 32'h12345678);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
